timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 126 ++++++++++++
 tb/tb_timer_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: four requesters share one external counter through an IDLE/LOAD/RUN/DONE FSM.
// Define TIMER_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.

module timer_arbiter_rank #(
  parameter int IDX = 0
) (
  input  logic [1:0] ptr,
  output logic [1:0] rank
);
  // Rank 0 is the slot right after ptr; the search order walks upward with wrap.
  assign rank = 2'(IDX) - ptr - 2'd1;
endmodule

module timer_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_len,
  input  logic              abort,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              ctr_enable,
  output logic              ctr_clear,
  output logic              ctr_wrap,
  output logic [N-1:0]      ctr_max,
  input  logic              ctr_at_max
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                 state, nxt;
  logic [1:0]             id_q, win_id, ptr;
  logic [N-1:0]           len_q;
  logic                   clr_q, found, abort_hit;
  logic [NREQ-1:0][N-1:0] slot_len;
  logic [NREQ-1:0][1:0]   rank;

  assign slot_len  = req_len;
  assign abort_hit = abort && (state == LOAD || state == RUN);
  assign ctr_wrap  = 1'b0;

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_rank
      timer_arbiter_rank #(.IDX(i)) u_rank (.ptr(ptr), .rank(rank[i]));
    end
  endgenerate

`ifdef TIMER_ARB_FIXED_PRIO_EN
  // A constant pointer of 3 makes rank equal the slot index.
  assign ptr = 2'd3;
`else
  logic [1:0] last_q;
  always_ff @(posedge clk) begin
    if (rst)                            last_q <= 2'd3;
    else if (state == DONE || abort_hit) last_q <= id_q;
  end
  assign ptr = last_q;
`endif

  always_comb begin
    win_id = '0;
    found  = 1'b0;
    for (int r = 0; r < NREQ; r++)
      for (int i = 0; i < NREQ; i++)
        if (!found && req[i] && rank[i] == 2'(r)) begin
          win_id = 2'(i);
          found  = 1'b1;
        end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id_q  <= '0;
      len_q <= '0;
      clr_q <= 1'b1;
    end else begin
      state <= nxt;
      // Holds the counter clear through the cycle after an abort.
      clr_q <= abort_hit;
      if (state == IDLE && |req) begin
        id_q  <= win_id;
        len_q <= slot_len[win_id];
      end
    end
  end

  always_comb begin
    nxt        = state;
    gnt        = '0;
    done       = '0;
    busy       = 1'b1;
    ctr_enable = 1'b0;
    ctr_clear  = clr_q;
    ctr_max    = len_q;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        ctr_max = '0;
        if (|req) nxt = LOAD;
      end
      LOAD: begin
        gnt[id_q] = 1'b1;
        ctr_clear = 1'b1;
        if (abort)             nxt = IDLE;
        else if (len_q == '0)  nxt = DONE;
        else                   nxt = RUN;
      end
      RUN: begin
        gnt[id_q]  = 1'b1;
        ctr_enable = 1'b1;
        if (abort)           nxt = IDLE;
        else if (ctr_at_max) nxt = DONE;
      end
      DONE: begin
        gnt[id_q]  = 1'b1;
        done[id_q] = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: N=8 instance for the main flow, N=4 instance for max length.
// Done pulses are checked against a queue of expected (one-hot id, cycle) entries.

module tb_timer_arbiter;
  typedef struct {
    logic [3:0] d;
    int         c;
  } exp_t;

  logic        tb_clk = 1'b0;
  logic        rst, abort;
  logic [3:0]  req, req4;
  logic [31:0] req_len;
  logic [15:0] req_len4;

  logic [3:0]  gnt, done, gnt4, done4;
  logic        busy, ctr_enable, ctr_clear, ctr_wrap, ctr_at_max;
  logic        busy4, ctr_enable4, ctr_clear4, ctr_wrap4, ctr_at_max4;
  logic [7:0]  ctr_max;
  logic [3:0]  ctr_max4;
  logic [15:0] cnt, cnt4;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0;
  logic mon_en = 1'b0;
  exp_t q[$], q4[$];
  exp_t e, e4;
  logic [3:0] oh;

`ifdef TIMER_ARB_FIXED_PRIO_EN
  int ord [5] = '{0, 0, 0, 0, 0};
`else
  int ord [5] = '{0, 1, 2, 3, 0};
`endif

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  timer_arbiter #(.N(8)) u_dut (
    .clk(tb_clk), .rst(rst), .req(req), .req_len(req_len), .abort(abort),
    .gnt(gnt), .done(done), .busy(busy), .ctr_enable(ctr_enable),
    .ctr_clear(ctr_clear), .ctr_wrap(ctr_wrap), .ctr_max(ctr_max),
    .ctr_at_max(ctr_at_max)
  );

  timer_arbiter #(.N(4)) u_dut4 (
    .clk(tb_clk), .rst(rst), .req(req4), .req_len(req_len4), .abort(1'b0),
    .gnt(gnt4), .done(done4), .busy(busy4), .ctr_enable(ctr_enable4),
    .ctr_clear(ctr_clear4), .ctr_wrap(ctr_wrap4), .ctr_max(ctr_max4),
    .ctr_at_max(ctr_at_max4)
  );

  // Shared-counter models: count per enabled cycle, at_max when count equals max.
  always @(posedge tb_clk) begin
    if (ctr_clear)       cnt <= '0;
    else if (ctr_enable) cnt <= cnt + 16'd1;
    if (ctr_clear4)       cnt4 <= '0;
    else if (ctr_enable4) cnt4 <= cnt4 + 16'd1;
  end
  assign ctr_at_max  = (cnt == 16'(ctr_max));
  assign ctr_at_max4 = (cnt4 == 16'(ctr_max4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  always @(posedge tb_clk) begin
    #1;
    if (mon_en) begin
      chk("wrap", ctr_wrap, 0);
      chk("wrap4", ctr_wrap4, 0);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      if (done !== 4'b0) begin
        if (q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          e = q.pop_front();
          chk("done_id", done, e.d);
          chk("done_cycle", cyc, e.c);
        end
      end
      if (done4 !== 4'b0) begin
        if (q4.size() == 0) chk("done4_unexpected", done4, 0);
        else begin
          e4 = q4.pop_front();
          chk("done4_id", done4, e4.d);
          chk("done4_cycle", cyc, e4.c);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; abort = 1'b0; req = '0; req4 = '0; req_len = '0; req_len4 = '0;
    repeat (2) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", ctr_enable, 0);
    chk("rst_clear", ctr_clear, 1);
    chk("rst_max", ctr_max, 0);
    chk("rst_wrap", ctr_wrap, 0);
    rst = 1'b0; mon_en = 1'b1;
    repeat (2) step();

    // Single job, length 3; req dropped and length changed mid-job
    t0 = cyc;
    req_len[16 +: 8] = 8'd3; req = 4'b0100;
    q.push_back('{d: 4'b0100, c: t0 + 6});
    step();
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_clear", ctr_clear, 1);
    chk("t1_load_en", ctr_enable, 0);
    chk("t1_busy", busy, 1);
    chk("t1_max", ctr_max, 3);
    step();
    chk("t1_run_en", ctr_enable, 1);
    chk("t1_run_clr", ctr_clear, 0);
    req = '0; req_len[16 +: 8] = 8'd7;
    step();
    chk("t1_max_held", ctr_max, 3);
    chk("t1_gnt_held", gnt, 4'b0100);
    repeat (3) step();
    chk("t1_done", done, 4'b0100);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_gnt", gnt, 0);
    chk("t1_idle_max", ctr_max, 0);

    // Zero length
    t0 = cyc;
    req_len[8 +: 8] = 8'd0; req = 4'b0010;
    q.push_back('{d: 4'b0010, c: t0 + 2});
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t2_no_enable", ctr_enable, 0);
      if (k == 2) req = '0;
    end
    step();

    // Round-robin fairness from reset, all lengths 1
    rst = 1'b1; step(); rst = 1'b0; step();
    t0 = cyc;
    req_len = {8'd1, 8'd1, 8'd1, 8'd1}; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << ord[k];
      q.push_back('{d: oh, c: t0 + 5 * k + 4});
    end
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << ord[k];
      step();
      chk("t3_gnt", gnt, oh);
      repeat (3) step();
      if (k == 4) req = '0;
      step();
      chk("t3_idle_busy", busy, 0);
      chk("t3_idle_done", done, 0);
    end

    // Abort in RUN; pointer moves past the aborted requester
    t0 = cyc;
    req_len[24 +: 8] = 8'd10; req = 4'b1000;
    repeat (4) step();
    chk("t4_run_en", ctr_enable, 1);
    abort = 1'b1;
    step();
    chk("t4_busy", busy, 0);
    chk("t4_gnt", gnt, 0);
    chk("t4_done", done, 0);
    chk("t4_clear", ctr_clear, 1);
    abort = 1'b0; req = 4'b1001; req_len[0 +: 8] = 8'd2;
    q.push_back('{d: 4'b0001, c: t0 + 10});
    step();
    chk("t4_next_gnt", gnt, 4'b0001);
    repeat (4) step();
    req = '0;
    repeat (2) step();

    // Reset mid-RUN; pointer back to 3 so requester 0 wins over 1
    t0 = cyc;
    req_len[0 +: 8] = 8'd5; req = 4'b0001;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("t5_gnt", gnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_clear", ctr_clear, 1);
    chk("t5_max", ctr_max, 0);
    rst = 1'b0; req = 4'b0011; req_len[0 +: 8] = 8'd1; req_len[8 +: 8] = 8'd1;
    q.push_back('{d: 4'b0001, c: t0 + 9});
    step();
    chk("t5_next_gnt", gnt, 4'b0001);
    repeat (3) step();
    req = '0;
    repeat (2) step();

    // Max length on the 4-bit instance
    t0 = cyc;
    req_len4[0 +: 4] = 4'd15; req4 = 4'b0001;
    q4.push_back('{d: 4'b0001, c: t0 + 18});
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("t6_max", ctr_max4, 15);
    end
    req4 = '0;
    step();
    chk("t6_busy", busy4, 0);
    chk("t6_idle_max", ctr_max4, 0);

    repeat (3) step();
    chk("q_empty", q.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
